// File: rtl/resize_pkg.sv
// Shared types and arithmetic helpers for the 2x2 box-filter downscaler.
package resize_pkg;

  localparam int PIX_W      = 8;
  localparam int SUM2_W     = 9;
  localparam int SUM4_W     = 10;
  localparam int ROUND_BIAS = 2;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic [SUM2_W-1:0] r;
    logic [SUM2_W-1:0] g;
    logic [SUM2_W-1:0] b;
  } sum2_t;

  function automatic logic [SUM2_W-1:0] add2(
    input logic [PIX_W-1:0] a,
    input logic [PIX_W-1:0] c
  );
    return SUM2_W'(a) + SUM2_W'(c);
  endfunction

  function automatic logic [SUM4_W-1:0] add4(
    input logic [SUM2_W-1:0] a,
    input logic [SUM2_W-1:0] c
  );
    return SUM4_W'(a) + SUM4_W'(c);
  endfunction

  // Round-half-up divide by four; a 10-bit sum of four bytes never overflows.
  function automatic logic [PIX_W-1:0] avg4(
    input logic [SUM4_W-1:0] s
  );
    logic [SUM4_W-1:0] t;
    t = s + SUM4_W'(ROUND_BIAS);
    return t[SUM4_W-1:2];
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row store of horizontal pair sums.
// Write is clocked, read is combinational.
import resize_pkg::*;

module line_buffer #(
  parameter int DEPTH = 192,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  sum2_t         wdata,
  input  logic [AW-1:0] raddr,
  output sum2_t         rdata
);

  sum2_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/downscale_2x2.sv
// Streaming 2:1 x 2:1 box-filter downscaler for RGB888 rasters.
// Emits one averaged pixel per 2x2 block, one cycle after its last input.
import resize_pkg::*;

module downscale_2x2 #(
  parameter  int WIDTH  = 384,
  parameter  int HEIGHT = 256,
  localparam int CW  = $clog2(WIDTH),
  localparam int RW  = $clog2(HEIGHT),
  localparam int OCW = (WIDTH  > 2) ? $clog2(WIDTH/2)  : 1,
  localparam int ORW = (HEIGHT > 2) ? $clog2(HEIGHT/2) : 1
) (
  input  logic             horizontal_clock,
  input  logic             horizontal_reset,
  input  logic             horizontal_sync,
  input  logic [PIX_W-1:0] r,
  input  logic [PIX_W-1:0] g,
  input  logic [PIX_W-1:0] b,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_r,
  output logic [PIX_W-1:0] out_g,
  output logic [PIX_W-1:0] out_b,
  output logic [ORW-1:0]   out_row,
  output logic [OCW-1:0]   out_col,
  output logic             frame_done
);

  logic [CW-1:0]  in_col;
  logic [RW-1:0]  in_row;
  rgb_t           hold;
  logic           last_col;
  logic           last_row;
  logic           odd_col;
  logic           odd_row;
  logic           wr_en;
  logic           emit;
  logic [OCW-1:0] addr;
  sum2_t          pair;
  sum2_t          above;
  rgb_t           avg;

  assign last_col = (in_col == CW'(WIDTH-1));
  assign last_row = (in_row == RW'(HEIGHT-1));
  assign odd_col  = in_col[0];
  assign odd_row  = in_row[0];
  assign addr     = OCW'(in_col >> 1);
  assign wr_en    = horizontal_sync & odd_col & ~odd_row;
  assign emit     = horizontal_sync & odd_col & odd_row;

  always_comb begin
    pair.r = add2(hold.r, r);
    pair.g = add2(hold.g, g);
    pair.b = add2(hold.b, b);
    avg.r  = avg4(add4(above.r, pair.r));
    avg.g  = avg4(add4(above.g, pair.g));
    avg.b  = avg4(add4(above.b, pair.b));
  end

  line_buffer #(
    .DEPTH (WIDTH/2),
    .AW    (OCW)
  ) u_lb (
    .clk   (horizontal_clock),
    .we    (wr_en),
    .waddr (addr),
    .wdata (pair),
    .raddr (addr),
    .rdata (above)
  );

  always_ff @(posedge horizontal_clock or negedge horizontal_reset) begin
    if (!horizontal_reset) begin
      in_col <= '0;
      in_row <= '0;
      hold   <= '0;
    end else if (horizontal_sync) begin
      in_col <= last_col ? '0 : in_col + 1'b1;
      if (last_col) in_row <= last_row ? '0 : in_row + 1'b1;
      if (!odd_col) hold <= '{r: r, g: g, b: b};
    end
  end

  always_ff @(posedge horizontal_clock or negedge horizontal_reset) begin
    if (!horizontal_reset) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_r      <= '0;
      out_g      <= '0;
      out_b      <= '0;
      out_row    <= '0;
      out_col    <= '0;
    end else begin
      out_valid  <= emit;
      frame_done <= emit & last_col & last_row;
      if (emit) begin
        out_r   <= avg.r;
        out_g   <= avg.g;
        out_b   <= avg.b;
        out_row <= ORW'(in_row >> 1);
        out_col <= addr;
      end
    end
  end

endmodule

// File: tb/tb_downscale_2x2.sv
// Randomised self-checking bench for downscale_2x2 against a block-average
// reference computed directly from the stored input frame.
module tb_downscale_2x2;

  localparam int W = 8;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync;
  logic [7:0] r, g, b;
  logic       out_valid;
  logic [7:0] out_r, out_g, out_b;
  logic [0:0] out_row;
  logic [1:0] out_col;
  logic       frame_done;

  downscale_2x2 #(.WIDTH(W), .HEIGHT(H)) dut (
    .horizontal_clock (clk),
    .horizontal_reset (rst_n),
    .horizontal_sync  (sync),
    .r                (r),
    .g                (g),
    .b                (b),
    .out_valid        (out_valid),
    .out_r            (out_r),
    .out_g            (out_g),
    .out_b            (out_b),
    .out_row          (out_row),
    .out_col          (out_col),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fd_cnt;
  int out_cnt;

  logic [7:0] pr [H][W];
  logic [7:0] pg [H][W];
  logic [7:0] pb [H][W];
  logic [7:0] got_r [H/2][W/2];
  logic [7:0] got_g [H/2][W/2];
  logic [7:0] got_b [H/2][W/2];
  logic [7:0] last_r, last_g, last_b;

  function automatic logic [7:0] box(input int s);
    return 8'((s + 2) / 4);
  endfunction

  function automatic int blk_sum(input int ch, input int by, input int bx);
    int s;
    s = 0;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++)
        case (ch)
          0: s += int'(pr[2*by+dy][2*bx+dx]);
          1: s += int'(pg[2*by+dy][2*bx+dx]);
          default: s += int'(pb[2*by+dy][2*bx+dx]);
        endcase
    return s;
  endfunction

  task automatic fill_const(input logic [7:0] cr, input logic [7:0] cg,
                            input logic [7:0] cb);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        pr[y][x] = cr; pg[y][x] = cg; pb[y][x] = cb;
      end
  endtask

  task automatic fill_rand();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        pr[y][x] = 8'($urandom);
        pg[y][x] = 8'($urandom);
        pb[y][x] = 8'($urandom);
      end
  endtask

  // Streams the stored frame, checking every cycle against the block model.
  task automatic run_frame(input int gap_max);
    logic [7:0] er, eg, eb;
    logic       efd;
    int         n;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (gap_max > 0 && $urandom_range(0, 2) == 0) begin
          n = $urandom_range(1, gap_max);
          sync = 1'b0;
          repeat (n) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid !== 1'b0 || frame_done !== 1'b0 ||
                out_r !== last_r || out_g !== last_g || out_b !== last_b)
              $display("FAIL gap_hold y=%0d x=%0d got v=%b fd=%b rgb=%0d/%0d/%0d want v=0 fd=0 rgb=%0d/%0d/%0d",
                       y, x, out_valid, frame_done, out_r, out_g, out_b,
                       last_r, last_g, last_b);
            else pass_cnt++;
          end
        end
        sync = 1'b1;
        r = pr[y][x]; g = pg[y][x]; b = pb[y][x];
        @(posedge clk); #1;
        total_cnt++;
        if ((y % 2) == 1 && (x % 2) == 1) begin
          er  = box(blk_sum(0, y/2, x/2));
          eg  = box(blk_sum(1, y/2, x/2));
          eb  = box(blk_sum(2, y/2, x/2));
          efd = (y == H-1) && (x == W-1);
          if (out_valid !== 1'b1 || out_r !== er || out_g !== eg ||
              out_b !== eb || int'(out_row) != y/2 || int'(out_col) != x/2 ||
              frame_done !== efd)
            $display("FAIL strobe y=%0d x=%0d got v=%b rgb=%0d/%0d/%0d rc=%0d,%0d fd=%b want v=1 rgb=%0d/%0d/%0d rc=%0d,%0d fd=%b",
                     y, x, out_valid, out_r, out_g, out_b, out_row, out_col,
                     frame_done, er, eg, eb, y/2, x/2, efd);
          else pass_cnt++;
          got_r[y/2][x/2] = out_r;
          got_g[y/2][x/2] = out_g;
          got_b[y/2][x/2] = out_b;
          last_r = er; last_g = eg; last_b = eb;
          if (out_valid === 1'b1) out_cnt++;
          if (frame_done === 1'b1) fd_cnt++;
        end else begin
          if (out_valid !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL idle y=%0d x=%0d got v=%b fd=%b want v=0 fd=0",
                     y, x, out_valid, frame_done);
          else pass_cnt++;
        end
      end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sync  = 1'b1;
    repeat (3) begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_r !== 8'd0 ||
          out_g !== 8'd0 || out_b !== 8'd0 || out_row !== 1'b0 ||
          out_col !== 2'd0)
        $display("FAIL reset_state got v=%b fd=%b rgb=%0d/%0d/%0d rc=%0d,%0d want all 0",
                 out_valid, frame_done, out_r, out_g, out_b, out_row, out_col);
      else pass_cnt++;
    end
    sync  = 1'b0;
    rst_n = 1'b1;
    last_r = 0; last_g = 0; last_b = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_constant();
    fill_const(8'd10, 8'd20, 8'd30);
    fd_cnt = 0; out_cnt = 0;
    run_frame(0);
    sync = 1'b0;
    total_cnt++;
    if (fd_cnt != 1 || out_cnt != 8)
      $display("FAIL const_counts got strobes=%0d fd=%0d want strobes=8 fd=1",
               out_cnt, fd_cnt);
    else pass_cnt++;
    for (int i = 0; i < (H/2)*(W/2); i++) begin
      total_cnt++;
      if (got_r[i/(W/2)][i%(W/2)] !== 8'd10 ||
          got_g[i/(W/2)][i%(W/2)] !== 8'd20 ||
          got_b[i/(W/2)][i%(W/2)] !== 8'd30)
        $display("FAIL const_colour blk=%0d got %0d/%0d/%0d want 10/20/30", i,
                 got_r[i/(W/2)][i%(W/2)], got_g[i/(W/2)][i%(W/2)],
                 got_b[i/(W/2)][i%(W/2)]);
      else pass_cnt++;
    end
  endtask

  task automatic test_rounding();
    logic [7:0] want [4];
    fill_rand();
    want[0] = 8'd1; want[1] = 8'd1; want[2] = 8'd0; want[3] = 8'd255;
    pr[0][0] = 1; pr[0][1] = 1; pr[1][0] = 1; pr[1][1] = 0;
    pr[0][2] = 1; pr[0][3] = 1; pr[1][2] = 0; pr[1][3] = 0;
    pr[0][4] = 1; pr[0][5] = 0; pr[1][4] = 0; pr[1][5] = 0;
    pr[0][6] = 255; pr[0][7] = 255; pr[1][6] = 255; pr[1][7] = 255;
    fd_cnt = 0; out_cnt = 0;
    run_frame(0);
    sync = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total_cnt++;
      if (got_r[0][c] !== want[c])
        $display("FAIL rounding col=%0d got %0d want %0d", c, got_r[0][c], want[c]);
      else pass_cnt++;
    end
  endtask

  task automatic test_gradient();
    fill_rand();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) pr[y][x] = 8'(x);
    fd_cnt = 0; out_cnt = 0;
    run_frame(0);
    sync = 1'b0;
    for (int c = 0; c < W/2; c++) begin
      total_cnt++;
      if (int'(got_r[0][c]) != 2*c + 1)
        $display("FAIL gradient col=%0d got %0d want %0d", c, got_r[0][c], 2*c + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_random_gaps();
    for (int f = 0; f < 3; f++) begin
      fill_rand();
      fd_cnt = 0; out_cnt = 0;
      run_frame(7);
      total_cnt++;
      if (fd_cnt != 1 || out_cnt != 8)
        $display("FAIL gaps_counts frame=%0d got strobes=%0d fd=%0d want strobes=8 fd=1",
                 f, out_cnt, fd_cnt);
      else pass_cnt++;
    end
    sync = 1'b0;
  endtask

  task automatic test_reset_mid();
    fill_rand();
    sync = 1'b1;
    for (int i = 0; i < 13; i++) begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_r !== 8'd0 ||
        out_g !== 8'd0 || out_b !== 8'd0 || out_row !== 1'b0 || out_col !== 2'd0)
      $display("FAIL mid_reset_async got v=%b fd=%b rgb=%0d/%0d/%0d rc=%0d,%0d want all 0",
               out_valid, frame_done, out_r, out_g, out_b, out_row, out_col);
    else pass_cnt++;
    sync = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_r = 0; last_g = 0; last_b = 0;
    fd_cnt = 0; out_cnt = 0;
    run_frame(3);
    sync = 1'b0;
    total_cnt++;
    if (fd_cnt != 1 || out_cnt != 8)
      $display("FAIL mid_reset_counts got strobes=%0d fd=%0d want strobes=8 fd=1",
               out_cnt, fd_cnt);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    fd_cnt = 0; out_cnt = 0;
    fill_const(8'd200, 8'd100, 8'd50);
    run_frame(0);
    fill_const(8'd7, 8'd77, 8'd177);
    run_frame(0);
    sync = 1'b0;
    total_cnt++;
    if (fd_cnt != 2 || out_cnt != 16)
      $display("FAIL b2b_counts got strobes=%0d fd=%0d want strobes=16 fd=2",
               out_cnt, fd_cnt);
    else pass_cnt++;
    for (int i = 0; i < (H/2)*(W/2); i++) begin
      total_cnt++;
      if (got_r[i/(W/2)][i%(W/2)] !== 8'd7 ||
          got_g[i/(W/2)][i%(W/2)] !== 8'd77 ||
          got_b[i/(W/2)][i%(W/2)] !== 8'd177)
        $display("FAIL b2b_colour blk=%0d got %0d/%0d/%0d want 7/77/177", i,
                 got_r[i/(W/2)][i%(W/2)], got_g[i/(W/2)][i%(W/2)],
                 got_b[i/(W/2)][i%(W/2)]);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sync  = 1'b0;
    r = 8'd0; g = 8'd0; b = 8'd0;
    last_r = 0; last_g = 0; last_b = 0;
    #1;
    test_reset();
    test_constant();
    test_rounding();
    test_gradient();
    test_random_gaps();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
